// File: rtl/jk_bank_scheduler_if.sv
// Purpose: bundles the two requester handshakes and the JK bank outputs of
//          jk_bank_scheduler.
// Signals:
//   reqN_valid/op/addr  requester N command (op encodes {J,K})
//   reqN_ready          requester N command accepted this cycle
//   j_out/k_out         J/K inputs of the external bank
//   q_shadow            scheduler's model of the bank Q outputs
//   busy                scheduler not idle
//   addr_err            one-cycle pulse for an out-of-range accepted command
// Modports: master = requester/bank side, slave = scheduler side.
interface jk_bank_scheduler_if #(
  parameter int unsigned NUM_FF = 8,
  parameter int unsigned ADDR_W = 3
);
  logic              req0_valid;
  logic [1:0]        req0_op;
  logic [ADDR_W-1:0] req0_addr;
  logic              req0_ready;
  logic              req1_valid;
  logic [1:0]        req1_op;
  logic [ADDR_W-1:0] req1_addr;
  logic              req1_ready;
  logic [NUM_FF-1:0] j_out;
  logic [NUM_FF-1:0] k_out;
  logic [NUM_FF-1:0] q_shadow;
  logic              busy;
  logic              addr_err;

  modport master (
    output req0_valid, req0_op, req0_addr, req1_valid, req1_op, req1_addr,
    input  req0_ready, req1_ready, j_out, k_out, q_shadow, busy, addr_err
  );

  modport slave (
    input  req0_valid, req0_op, req0_addr, req1_valid, req1_op, req1_addr,
    output req0_ready, req1_ready, j_out, k_out, q_shadow, busy, addr_err
  );
endinterface

// File: rtl/jk_bank_scheduler.sv
// Purpose: round-robin scheduler that applies single hold/clear/set/toggle
//          commands from two requesters to a bank of external JK flops,
//          one drive cycle per command followed by a settle interval, and
//          keeps a shadow copy of the bank state.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    jk_bank_scheduler_if.slave (requester handshakes + bank outputs)
module jk_bank_scheduler #(
  parameter int unsigned NUM_FF        = 8,
  parameter int unsigned ADDR_W        = 3,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  jk_bank_scheduler_if.slave    bus
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE
  } state_e;

  state_e            state_q, state_d;
  logic              rr_q, rr_d;          // 1: requester 1 favoured on a tie
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_FF-1:0] j_q, j_d;
  logic [NUM_FF-1:0] k_q, k_d;
  logic [NUM_FF-1:0] shadow_q, shadow_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic              grant0_c, grant1_c;
  logic [NUM_FF-1:0] cur_mask_c, nxt_mask_c;

  // One-hot select of a flop; out-of-range indices shift out to all-zero.
  function automatic logic [NUM_FF-1:0] onehot(input logic [ADDR_W-1:0] a);
    return NUM_FF'(1) << a;
  endfunction

  // Round-robin grant, only meaningful while idle.
  assign grant0_c = bus.req0_valid && (!bus.req1_valid || !rr_q);
  assign grant1_c = bus.req1_valid && (!bus.req0_valid ||  rr_q);

  assign bus.req0_ready = (state_q == ST_IDLE) && grant0_c;
  assign bus.req1_ready = (state_q == ST_IDLE) && grant1_c;

  assign bus.j_out    = j_q;
  assign bus.k_out    = k_q;
  assign bus.q_shadow = shadow_q;
  assign bus.busy     = busy_q;
  assign bus.addr_err = err_q;

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rr_q     <= 1'b0;
      op_q     <= 2'b00;
      addr_q   <= '0;
      cnt_q    <= '0;
      j_q      <= '0;
      k_q      <= '0;
      shadow_q <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      j_q      <= j_d;
      k_q      <= k_d;
      shadow_q <= shadow_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic; registered outputs are derived from the next state so
  // they line up with the cycle the FSM is in.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    op_d       = op_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    j_d        = '0;
    k_d        = '0;
    err_d      = 1'b0;
    cur_mask_c = onehot(addr_q);

    case (state_q)
      ST_IDLE: begin
        if (grant0_c) begin
          op_d    = bus.req0_op;
          addr_d  = bus.req0_addr;
          rr_d    = 1'b1;
          state_d = ST_DRIVE;
        end else if (grant1_c) begin
          op_d    = bus.req1_op;
          addr_d  = bus.req1_addr;
          rr_d    = 1'b0;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        // Shadow updates on the same edge the external flop captures J/K.
        case (op_q)
          2'b01:   shadow_d = shadow_q & ~cur_mask_c;
          2'b10:   shadow_d = shadow_q |  cur_mask_c;
          2'b11:   shadow_d = shadow_q ^  cur_mask_c;
          default: shadow_d = shadow_q;
        endcase
        if (SETTLE_CYCLES > 0) begin
          cnt_d   = CNT_W'(SETTLE_CYCLES);
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    nxt_mask_c = onehot(addr_d);
    if (state_d == ST_DRIVE) begin
      j_d   = {NUM_FF{op_d[1]}} & nxt_mask_c;
      k_d   = {NUM_FF{op_d[0]}} & nxt_mask_c;
      err_d = (nxt_mask_c == '0);
    end
    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_jk_bank_scheduler.sv
module tb_jk_bank_scheduler;

  localparam int unsigned NUM_FF = 8;
  localparam int unsigned ADDR_W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance 0: SETTLE_CYCLES=1, instance 1: SETTLE_CYCLES=0.
  jk_bank_scheduler_if #(.NUM_FF(NUM_FF), .ADDR_W(ADDR_W)) bus0 ();
  jk_bank_scheduler_if #(.NUM_FF(NUM_FF), .ADDR_W(ADDR_W)) bus1 ();

  jk_bank_scheduler #(.NUM_FF(NUM_FF), .ADDR_W(ADDR_W), .SETTLE_CYCLES(1)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  jk_bank_scheduler #(.NUM_FF(NUM_FF), .ADDR_W(ADDR_W), .SETTLE_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  logic              vld [2][2];
  logic [1:0]        op  [2][2];
  logic [ADDR_W-1:0] adr [2][2];
  logic              rdy [2][2];
  logic [NUM_FF-1:0] jo [2], ko [2], qs [2];
  logic              bsy [2], aerr [2];

  assign bus0.req0_valid = vld[0][0];
  assign bus0.req0_op    = op[0][0];
  assign bus0.req0_addr  = adr[0][0];
  assign bus0.req1_valid = vld[0][1];
  assign bus0.req1_op    = op[0][1];
  assign bus0.req1_addr  = adr[0][1];
  assign bus1.req0_valid = vld[1][0];
  assign bus1.req0_op    = op[1][0];
  assign bus1.req0_addr  = adr[1][0];
  assign bus1.req1_valid = vld[1][1];
  assign bus1.req1_op    = op[1][1];
  assign bus1.req1_addr  = adr[1][1];

  assign rdy[0][0] = bus0.req0_ready;
  assign rdy[0][1] = bus0.req1_ready;
  assign rdy[1][0] = bus1.req0_ready;
  assign rdy[1][1] = bus1.req1_ready;
  assign jo[0] = bus0.j_out;    assign jo[1] = bus1.j_out;
  assign ko[0] = bus0.k_out;    assign ko[1] = bus1.k_out;
  assign qs[0] = bus0.q_shadow; assign qs[1] = bus1.q_shadow;
  assign bsy[0] = bus0.busy;    assign bsy[1] = bus1.busy;
  assign aerr[0] = bus0.addr_err; assign aerr[1] = bus1.addr_err;

  // Reference model: a command occupies cycles 0..settle after its accept
  // edge; cycle 0 is the drive cycle, the shadow applies at its end.
  int          settle_m [2];
  bit          act [2];
  int          age [2];
  bit          fav1 [2];
  logic [1:0]  mop [2];
  int          maddr [2];
  logic [7:0]  mq [2];
  int          last_acc [2];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int exp_grant(int i);
    if (act[i]) return -1;
    if (vld[i][0] && (!vld[i][1] || !fav1[i])) return 0;
    if (vld[i][1]) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      act[i] = 0; age[i] = 0; fav1[i] = 0; mop[i] = 2'b00; maddr[i] = 0;
      mq[i] = 8'h00; last_acc[i] = -1;
    end
  endtask

  task automatic check_outputs(int i);
    int   g;
    bit   drv;
    logic [7:0] mask;
    g    = exp_grant(i);
    drv  = act[i] && (age[i] == 0);
    mask = (maddr[i] < NUM_FF) ? (8'h01 << maddr[i]) : 8'h00;
    check_eq($sformatf("i%0d_ready0", i), 32'(rdy[i][0]), 32'(g == 0));
    check_eq($sformatf("i%0d_ready1", i), 32'(rdy[i][1]), 32'(g == 1));
    check_eq($sformatf("i%0d_busy", i), 32'(bsy[i]), 32'(act[i]));
    check_eq($sformatf("i%0d_j_out", i), 32'(jo[i]), 32'((drv && mop[i][1]) ? mask : 8'h00));
    check_eq($sformatf("i%0d_k_out", i), 32'(ko[i]), 32'((drv && mop[i][0]) ? mask : 8'h00));
    check_eq($sformatf("i%0d_addr_err", i), 32'(aerr[i]), 32'(drv && (maddr[i] >= NUM_FF)));
    check_eq($sformatf("i%0d_q_shadow", i), 32'(qs[i]), 32'(mq[i]));
  endtask

  task automatic model_step(int i, int g);
    logic [7:0] mask;
    if (act[i]) begin
      if (age[i] == 0) begin
        mask = (maddr[i] < NUM_FF) ? (8'h01 << maddr[i]) : 8'h00;
        case (mop[i])
          2'b01: mq[i] = mq[i] & ~mask;
          2'b10: mq[i] = mq[i] | mask;
          2'b11: mq[i] = mq[i] ^ mask;
          default: ;
        endcase
      end
      age[i]++;
      if (age[i] > settle_m[i]) act[i] = 0;
    end else if (g >= 0) begin
      act[i]   = 1;
      age[i]   = 0;
      mop[i]   = op[i][g];
      maddr[i] = int'(adr[i][g]);
      fav1[i]  = (g == 0);
    end
  endtask

  // Check both instances, then advance one clock and step the model.
  task automatic cycle();
    int g [2];
    #2;
    for (int i = 0; i < 2; i++) begin
      check_outputs(i);
      g[i] = exp_grant(i);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      model_step(i, g[i]);
      last_acc[i] = g[i];
    end
  endtask

  task automatic set_req(int i, int r, logic v, logic [1:0] o, int a);
    vld[i][r] = v;
    op[i][r]  = o;
    adr[i][r] = ADDR_W'(a);
  endtask

  task automatic drive_random();
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (vld[i][r] && last_acc[i] != r) begin
          if ($urandom_range(0, 9) == 0) vld[i][r] = 1'b0;
        end else begin
          set_req(i, r, ($urandom_range(0, 2) != 0), 2'($urandom), int'($urandom_range(0, 9)));
        end
      end
    end
  endtask

  int n_tog;

  initial begin
    settle_m[0] = 1;
    settle_m[1] = 0;
    model_reset();
    for (int i = 0; i < 2; i++)
      for (int r = 0; r < 2; r++) set_req(i, r, 1'b0, 2'b00, 0);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("i%0d_rst_busy", i), 32'(bsy[i]), 32'd0);
      check_eq($sformatf("i%0d_rst_q", i), 32'(qs[i]), 32'd0);
    end
    #11 reset = 1'b0;
    @(posedge clk);
    #1;
    cycle();

    // Single set of flop 3 from requester 0.
    for (int i = 0; i < 2; i++) set_req(i, 0, 1'b1, 2'b10, 3);
    cycle();
    for (int i = 0; i < 2; i++) vld[i][0] = 1'b0;
    repeat (4) cycle();
    check_eq("i0_set3_q", 32'(qs[0]), 32'h08);

    // Both requesters continuously valid: grants alternate.
    for (int i = 0; i < 2; i++) begin
      set_req(i, 0, 1'b1, 2'b10, 0);
      set_req(i, 1, 1'b1, 2'b10, 1);
    end
    repeat (12) cycle();
    for (int i = 0; i < 2; i++) begin
      vld[i][0] = 1'b0;
      vld[i][1] = 1'b0;
    end
    repeat (3) cycle();
    check_eq("i0_rr_q", 32'(qs[0]), 32'h0b);

    // Toggle flop 5 three times from requester 1 (bounded).
    for (int i = 0; i < 2; i++) set_req(i, 1, 1'b1, 2'b11, 5);
    n_tog = 0;
    for (int c = 0; c < 30 && n_tog < 3; c++) begin
      cycle();
      if (last_acc[0] == 1) n_tog++;
    end
    for (int i = 0; i < 2; i++) vld[i][1] = 1'b0;
    repeat (3) cycle();
    check_eq("i0_toggles", 32'(n_tog), 32'd3);
    check_eq("i0_tog5_q", 32'(qs[0][5]), 32'd1);

    // Out-of-range clear.
    for (int i = 0; i < 2; i++) set_req(i, 0, 1'b1, 2'b01, 9);
    cycle();
    for (int i = 0; i < 2; i++) vld[i][0] = 1'b0;
    repeat (3) cycle();

    // Reset asserted during a drive cycle.
    for (int i = 0; i < 2; i++) set_req(i, 0, 1'b1, 2'b10, 2);
    cycle();
    reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("i%0d_mid_rst_j", i), 32'(jo[i]), 32'd0);
      check_eq($sformatf("i%0d_mid_rst_k", i), 32'(ko[i]), 32'd0);
      check_eq($sformatf("i%0d_mid_rst_busy", i), 32'(bsy[i]), 32'd0);
      check_eq($sformatf("i%0d_mid_rst_q", i), 32'(qs[i]), 32'd0);
    end
    model_reset();
    #1 reset = 1'b0;
    for (int i = 0; i < 2; i++) set_req(i, 1, 1'b1, 2'b01, 4);
    cycle();
    for (int i = 0; i < 2; i++) begin
      vld[i][0] = 1'b0;
      vld[i][1] = 1'b0;
    end
    repeat (3) cycle();

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      drive_random();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
